// File: rtl/contador_ad_mod_bcd.sv
// contador_ad_mod_bcd: a BCD up/down counter for one field of a settable clock.
// The counter moves only while en_count selects it. It steps once on each
// rising edge of enUP/enDOWN and wraps between MIN_VAL and MAX_VAL. Each wrap
// gives a one-cycle carry or borrow pulse. digit1/digit0 are the decimal
// tens/units of q.
// Optional build macro CONTADOR_AUTOREPEAT_EN: a held button auto-repeats. The
// first repeat comes after REPEAT_DLY cycles and later repeats come every
// REPEAT_PER cycles. Without the macro a held button gives exactly one step.
`timescale 1ns/1ps

module contador_ad_mod_bcd #(
  parameter int W          = 7,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 23,
  parameter int FIELD_ID   = 10,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 12500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   en_count,
  input  logic         enUP,
  input  logic         enDOWN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic [3:0]   digit1,
  output logic [3:0]   digit0,
  output logic         carry,
  output logic         borrow
);

  // A bad parameter set is rejected while the design is elaborated, not at run time
  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99 || (1 << W) <= MAX_VAL ||
      FIELD_ID < 0 || FIELD_ID > 15 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : gBadParams
    $error("contador_ad_mod_bcd: invalid parameter set");
  end

  // Index 0 is the up direction and index 1 is the down direction
  logic         sel;
  logic [1:0]   req;
  logic [1:0]   reqPrev_q;
  logic         armed_q;
  logic [1:0]   edgeTick;
  logic [1:0]   step;
  logic         loadOk;
  logic [W-1:0] q_q, q_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic [6:0]   qBcd;

  assign sel    = (en_count == 4'(FIELD_ID));
  assign req    = {enDOWN, enUP};
  assign loadOk = (int'(load_val) >= MIN_VAL) && (int'(load_val) <= MAX_VAL);

  // armed_q stays low for the first cycle after reset. An input that was
  // already high while reset was asserted therefore cannot count. The user
  // must release the button and press it again.
  assign edgeTick = req & ~reqPrev_q & {2{sel & armed_q}};

  // Remember last cycle's inputs for edge detection, and arm after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqPrev_q <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      reqPrev_q <= req;
      armed_q   <= 1'b1;
    end
  end

`ifdef CONTADOR_AUTOREPEAT_EN
  localparam int RptMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW     = $clog2(RptMax + 1);

  logic [1:0][CW-1:0] rptCnt_q, rptCnt_d;
  logic [1:0]         rptActive_q, rptActive_d;
  logic [1:0]         rptLate_q, rptLate_d;
  logic [1:0]         rptFire;
  logic               bothHigh;

  assign bothHigh = enUP & enDOWN;

  // Per direction, count the cycles the button has been held since its edge or since the last repeat step.
  // The first repeat waits REPEAT_DLY cycles. rptLate_q then switches the wait to REPEAT_PER.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rptCnt_d[i]    = rptCnt_q[i];
      rptActive_d[i] = rptActive_q[i];
      rptLate_d[i]   = rptLate_q[i];
      rptFire[i]     = 1'b0;
      if (!req[i] || !sel || bothHigh) begin
        rptCnt_d[i]    = '0;
        rptActive_d[i] = 1'b0;
        rptLate_d[i]   = 1'b0;
      end else if (edgeTick[i]) begin
        rptCnt_d[i]    = '0;
        rptActive_d[i] = 1'b1;
        rptLate_d[i]   = 1'b0;
      end else if (rptActive_q[i]) begin
        if (rptLate_q[i] ? (rptCnt_q[i] == CW'(REPEAT_PER - 1))
                         : (rptCnt_q[i] == CW'(REPEAT_DLY - 1))) begin
          rptFire[i]   = 1'b1;
          rptCnt_d[i]  = '0;
          rptLate_d[i] = 1'b1;
        end else begin
          rptCnt_d[i]  = rptCnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Repeat state registers, cleared by reset so a held button starts over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptCnt_q    <= '0;
      rptActive_q <= 2'b00;
      rptLate_q   <= 2'b00;
    end else begin
      rptCnt_q    <= rptCnt_d;
      rptActive_q <= rptActive_d;
      rptLate_q   <= rptLate_d;
    end
  end

  assign step = edgeTick | rptFire;
`else
  assign step = edgeTick;
`endif

  // Next count. A selected load wins over any step. An up step and a down
  // step in the same cycle cancel each other. Only a real wrap raises carry or borrow.
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (sel && load) begin
      if (loadOk) begin
        q_d = load_val;
      end
    end else if (step == 2'b01) begin
      if (q_q == W'(MAX_VAL)) begin
        q_d     = W'(MIN_VAL);
        carry_d = 1'b1;
      end else begin
        q_d = q_q + W'(1);
      end
    end else if (step == 2'b10) begin
      if (q_q == W'(MIN_VAL)) begin
        q_d      = W'(MAX_VAL);
        borrow_d = 1'b1;
      end else begin
        q_d = q_q - W'(1);
      end
    end
  end

  // Count and wrap-pulse registers. Reset forces the count to MIN_VAL at once, with no clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= W'(MIN_VAL);
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Split the count into decimal digits. The count never exceeds 99, so 7 bits hold it.
  always_comb begin
    qBcd   = 7'(q_q);
    digit1 = 4'(qBcd / 7'd10);
    digit0 = 4'(qBcd % 7'd10);
  end

  assign q      = q_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_contador_ad_mod_bcd.sv
// Testbench for contador_ad_mod_bcd. Directed cases and random cases are
// scored against a behavioural model of the counter, which uses integer
// arithmetic. Build with CONTADOR_AUTOREPEAT_EN defined to include the held-button repeat case.
`timescale 1ns/1ps

module tb_contador_ad_mod_bcd;

  localparam int W      = 7;
  localparam int MinV   = 0;
  localparam int MaxV   = 23;
  localparam int FieldV = 10;
  localparam int Dly    = 4;
  localparam int Per    = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   en_count;
  logic         enUP, enDOWN, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [3:0]   digit1, digit0;
  logic         carry, borrow;

  typedef struct {
    int    q;
    bit    c;
    bit    b;
    string tag;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  int  mq;
  bit  mPrevUp, mPrevDn, mFresh;
  int  kUp, kDn;

  contador_ad_mod_bcd #(
    .W(W), .MIN_VAL(MinV), .MAX_VAL(MaxV), .FIELD_ID(FieldV),
    .REPEAT_DLY(Dly), .REPEAT_PER(Per)
  ) dut (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .load(load), .load_val(load_val), .q(q), .digit1(digit1), .digit0(digit0),
    .carry(carry), .borrow(borrow)
  );

  always #5 clk = ~clk;

  // Compare all outputs against one expected state
  task automatic checkOutput(input string tag, input int eq, input bit ec, input bit eb);
    checks++;
    if (int'(q) != eq || int'(digit1) != eq / 10 || int'(digit0) != eq % 10 ||
        carry !== ec || borrow !== eb) begin
      failures++;
      $display("[TB] FAIL %s: got q=%0d d=%0d%0d c=%b b=%b, want q=%0d d=%0d%0d c=%b b=%b",
               tag, q, digit1, digit0, carry, borrow, eq, eq / 10, eq % 10, ec, eb);
    end
  endtask

  // Model for repeat steps: a step occurs when the press has been held exactly Dly cycles past its edge, then every Per cycles
  function automatic bit repeatDue(input int k);
    return (k == Dly) || (k > Dly && ((k - Dly) % Per) == 0);
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected result
  task automatic applyStimulus(input bit up, input bit dn, input bit ld, input int lv,
                               input int ec, input string tag);
    bit sel, upEdge, dnEdge, upStep, dnStep, c, b;
    en_count = 4'(ec);
    enUP     = up;
    enDOWN   = dn;
    load     = ld;
    load_val = W'(lv);
    sel    = (ec == FieldV);
    upEdge = up && !mPrevUp && sel && !mFresh;
    dnEdge = dn && !mPrevDn && sel && !mFresh;
    upStep = upEdge;
    dnStep = dnEdge;
`ifdef CONTADOR_AUTOREPEAT_EN
    if (!up || !sel || (up && dn)) kUp = -1;
    else if (upEdge) kUp = 0;
    else if (kUp >= 0) begin kUp++; if (repeatDue(kUp)) upStep = 1'b1; end
    if (!dn || !sel || (up && dn)) kDn = -1;
    else if (dnEdge) kDn = 0;
    else if (kDn >= 0) begin kDn++; if (repeatDue(kDn)) dnStep = 1'b1; end
`endif
    c = 1'b0;
    b = 1'b0;
    if (sel && ld) begin
      if (lv >= MinV && lv <= MaxV) mq = lv;
    end else if (upStep && !dnStep) begin
      if (mq == MaxV) begin mq = MinV; c = 1'b1; end else mq = mq + 1;
    end else if (dnStep && !upStep) begin
      if (mq == MinV) begin mq = MaxV; b = 1'b1; end else mq = mq - 1;
    end
    mPrevUp = up;
    mPrevDn = dn;
    mFresh  = 1'b0;
    expQ.push_back('{q: mq, c: c, b: b, tag: tag});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle and expect the count to clear before any clock edge
  task automatic doReset(input string tag);
    reset = 1'b1;
    #1;
    checkOutput(tag, MinV, 1'b0, 1'b0);
    mq = MinV; mPrevUp = 1'b0; mPrevDn = 1'b0; mFresh = 1'b1; kUp = -1; kDn = -1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: just after every rising edge, pop one queued expectation and compare
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.tag, e.q, e.c, e.b);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus
  initial begin
    bit rUp, rDn, rLd;
    int rEc, rLv;
    reset = 1'b0; en_count = 4'(FieldV); enUP = 0; enDOWN = 0; load = 0; load_val = '0;
    #12;
    doReset("reset_initial");

    // Up wrap from 23
    applyStimulus(0, 0, 1, 23, FieldV, "load23");
    applyStimulus(1, 0, 0, 0, FieldV, "up_wrap");
    applyStimulus(0, 0, 0, 0, FieldV, "carry_drop");

    // Down wrap with a long hold: one step only when auto-repeat is off
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, FieldV, "down_hold");
    applyStimulus(0, 0, 0, 0, FieldV, "down_release");

    // Simultaneous edges, then a deselected field
    applyStimulus(1, 1, 0, 0, FieldV, "both_edges");
    applyStimulus(0, 0, 0, 0, FieldV, "both_release");
    applyStimulus(1, 0, 0, 0, 5, "deselected_up");
    applyStimulus(0, 0, 0, 0, 5, "deselected_release");
    applyStimulus(0, 0, 1, 3, 5, "deselected_load");

    // Load in range, load out of range, load beats an up edge
    applyStimulus(0, 0, 1, 15, FieldV, "load15");
    applyStimulus(0, 0, 1, 30, FieldV, "load30_ignored");
    applyStimulus(1, 0, 0, 0, FieldV, "up_to16");
    applyStimulus(0, 0, 0, 0, FieldV, "idle");
    applyStimulus(1, 0, 1, 15, FieldV, "load_beats_up");
    applyStimulus(0, 0, 0, 0, FieldV, "idle");
    applyStimulus(0, 0, 1, 24, FieldV, "load24_ignored");

    // Async reset mid-count at 17
    applyStimulus(0, 0, 1, 17, FieldV, "load17");
    doReset("reset_mid_count");

    // A button held through reset must not count after reset releases
    applyStimulus(1, 0, 0, 0, FieldV, "pre_hold");
    enUP = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("reset_with_hold", MinV, 1'b0, 1'b0);
    mq = MinV; mPrevUp = 1'b0; mPrevDn = 1'b0; mFresh = 1'b1; kUp = -1; kDn = -1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, FieldV, "held_across_reset");
    applyStimulus(1, 0, 0, 0, FieldV, "held_across_reset2");
    applyStimulus(0, 0, 0, 0, FieldV, "release");
    applyStimulus(1, 0, 0, 0, FieldV, "fresh_edge");
    applyStimulus(0, 0, 0, 0, FieldV, "release");

`ifdef CONTADOR_AUTOREPEAT_EN
    // Held up from 0: steps at the edge, +4, +6, +8
    applyStimulus(0, 0, 1, 0, FieldV, "load0");
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, FieldV, "auto_repeat");
    applyStimulus(0, 0, 0, 0, FieldV, "auto_release");
`endif

    // Random mix of holds, loads and field selects
    rUp = 0; rDn = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rUp = ~rUp;
      if ($urandom_range(0, 3) == 0) rDn = ~rDn;
      rEc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : FieldV;
      rLd = ($urandom_range(0, 15) == 0);
      rLv = int'($urandom_range(0, 40));
      applyStimulus(rUp, rDn, rLd, rLv, rEc, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
